// File: rtl/cla_seq_adder.sv
`default_nettype none
// ============================================================================
// Module   : cla_seq_adder
// Purpose  : Multi-cycle WIDTH-bit add/subtract. Each clock adds one
//            CHUNK-bit slice and keeps the inter-slice carry in a register.
//            Operands arrive and results leave over valid/ready handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module cla_seq_adder #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Latched operands; b_q already holds ~b for subtraction.
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  // Slice under computation this cycle.
  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic [CHUNK-1:0] s_sl;
  logic             c_out;
  logic             c_msb;
  logic             last_slice;

  assign in_ready   = (state == IDLE);
  assign last_slice = (cnt == LAST);

  // Slice adder: selects slice cnt and adds it with the carry register.
  // c_msb recovers the carry into the slice MSB for overflow detection.
  always_comb begin
    a_sl  = a_q[cnt*CHUNK +: CHUNK];
    b_sl  = b_q[cnt*CHUNK +: CHUNK];
    {c_out, s_sl} = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry};
    c_msb = a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ s_sl[CHUNK-1];
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)   state_nxt = RUN;
      RUN:     if (last_slice) state_nxt = DONE;
      DONE:    if (out_ready)  state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Operand capture, slice accumulation and result flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q       <= '0;
      b_q       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          sum[cnt*CHUNK +: CHUNK] <= s_sl;
          carry <= c_out;
          cnt   <= cnt + 1'b1;
          if (last_slice) begin
            cout      <= c_out;
            ovf       <= c_msb ^ c_out;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cla_seq_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_seq_adder
// Purpose  : Self-checking bench for cla_seq_adder (WIDTH=64, CHUNK=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cla_seq_adder;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] sum;
  logic        cout;
  logic        ovf;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;
    logic [63:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [9];

  cla_seq_adder #(.WIDTH(64), .CHUNK(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Presents one operation at a negedge; returns at the negedge after the accepting edge.
  task automatic start_op(input logic [63:0] va, input logic [63:0] vb, input logic vc, input logic vs);
    a = va; b = vb; cin = vc; sub = vs; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts edges after acceptance until out_valid; -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [63:0] hold_sum;
    logic        hold_cout;
    logic        hold_ovf;
    logic [63:0] ra, rb, rbp, msum;
    logic        rc, rs, rcin, mcout, movf;
    logic        seen;

    vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0};
    vecs[1] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[2] = '{64'h5, 64'h7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vecs[3] = '{64'h7, 64'h5, 1'b0, 1'b1, 64'h2, 1'b1, 1'b0};
    vecs[4] = '{64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vecs[5] = '{64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0};
    vecs[6] = '{64'h0, 64'h0, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0};
    vecs[7] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1};
    vecs[8] = '{64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b1, 1'b0,
                64'h2345_6789_ABCD_F002, 1'b0, 1'b0};

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", sum, 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed vector table
    for (int v = 0; v < 9; v++) begin
      chk($sformatf("v%0d_in_ready", v), 64'(in_ready), 64'd1);
      start_op(vecs[v].a, vecs[v].b, vecs[v].cin, vecs[v].sub);
      chk($sformatf("v%0d_busy", v), 64'(in_ready), 64'd0);
      wait_done(lat);
      chk($sformatf("v%0d_latency", v), 64'(lat), 64'd4);
      chk($sformatf("v%0d_sum", v), sum, vecs[v].exp_sum);
      chk($sformatf("v%0d_cout", v), 64'(cout), 64'(vecs[v].exp_cout));
      chk($sformatf("v%0d_ovf", v), 64'(ovf), 64'(vecs[v].exp_ovf));
      if (v != 8) release_result();
    end

    // Back-pressure: last vector's result held while inputs churn
    hold_sum = sum; hold_cout = cout; hold_ovf = ovf;
    for (int i = 0; i < 10; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      in_valid = ~in_valid;
      @(negedge clk);
      chk("bp_sum", sum, 64'h2345_6789_ABCD_F002);
      chk("bp_flags", {62'd0, cout, ovf}, {62'd0, hold_cout, hold_ovf});
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
    end
    if (hold_sum !== sum) chk("bp_hold", sum, hold_sum);
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    chk("bp_release_out_valid", 64'(out_valid), 64'd0);

    // Async reset two edges into RUN
    start_op(64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_sum", sum, 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("arst_no_result", 64'(seen), 64'd0);

    // Random operations against a (WIDTH+1)-bit reference with output stalls
    for (int n = 0; n < 60; n++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (n % 4 == 0) rb = ~ra;
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      rbp  = rs ? ~rb : rb;
      rcin = rs ? 1'b1 : rc;
      {mcout, msum} = {1'b0, ra} + {1'b0, rbp} + {64'd0, rcin};
      movf = (ra[63] == rbp[63]) && (msum[63] != ra[63]);
      start_op(ra, rb, rc, rs);
      wait_done(lat);
      chk($sformatf("r%0d_latency", n), 64'(lat), 64'd4);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      chk($sformatf("r%0d_sum", n), sum, msum);
      chk($sformatf("r%0d_flags", n), {62'd0, cout, ovf}, {62'd0, mcout, movf});
      release_result();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
